// File: rtl/lighthouse_sample_arbiter.sv
// Collects decoder words from NUM_SENSORS lighthouse decoders into per-sensor holding slots,
// then round-robin merges them into one tagged first-word-fall-through FIFO.
module lighthouse_sample_arbiter #(
    parameter int unsigned NUM_SENSORS = 8,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [32*NUM_SENSORS-1:0]     sensor_data,
    input  logic [NUM_SENSORS-1:0]        data_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic [ID_WIDTH-1:0]           out_id,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_count,
    input  logic                          clear_overflow
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ID_WIDTH + 32;
    localparam int unsigned EV_W    = $clog2(NUM_SENSORS + 1);

    logic [31:0]            word_in [NUM_SENSORS];
    logic [31:0]            hold    [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] pending;
    logic [ID_WIDTH-1:0]    last_grant;

    logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [ENTRY_W-1:0]     head;

    logic                   found_hi;
    logic                   found_lo;
    logic [ID_WIDTH-1:0]    sel_hi;
    logic [ID_WIDTH-1:0]    sel_lo;
    logic                   grant_valid;
    logic [ID_WIDTH-1:0]    grant_id;
    logic [NUM_SENSORS-1:0] grant_onehot;
    logic [31:0]            grant_word;
    logic [NUM_SENSORS-1:0] pending_next;
    logic [EV_W-1:0]        ovf_events;
    logic [16:0]            ovf_sum;
    logic [15:0]            ovf_next;
    logic                   push;
    logic                   pop;
    logic [LVL_W-1:0]       level_next;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_unpack
        assign word_in[g] = sensor_data[32*g +: 32];
    end

    // Round-robin pick: lowest pending index above last_grant, else lowest pending overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int i = int'(NUM_SENSORS) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                found_lo = 1'b1;
                sel_lo   = ID_WIDTH'(i);
                if (ID_WIDTH'(i) > last_grant) begin
                    found_hi = 1'b1;
                    sel_hi   = ID_WIDTH'(i);
                end
            end
        end
        grant_valid = (found_hi | found_lo) && (fifo_level < LVL_W'(FIFO_DEPTH));
        grant_id    = found_hi ? sel_hi : sel_lo;
    end

    // A granted slot ships its old word, so a same-cycle strobe on it is not an overwrite.
    always_comb begin
        grant_onehot = '0;
        grant_word   = '0;
        ovf_events   = '0;
        for (int i = 0; i < int'(NUM_SENSORS); i++) begin
            if (grant_valid && (grant_id == ID_WIDTH'(i))) begin
                grant_onehot[i] = 1'b1;
                grant_word      = hold[i];
            end
            if (data_ready[i] && pending[i] && !grant_onehot[i]) begin
                ovf_events = ovf_events + EV_W'(1);
            end
        end
        pending_next = data_ready | (pending & ~grant_onehot);
    end

    // Saturating overwrite counter; clear still counts events of its own cycle.
    always_comb begin
        ovf_sum = {1'b0, overflow_count} + 17'(ovf_events);
        if (clear_overflow) begin
            ovf_next = 16'(ovf_events);
        end else if (ovf_sum[16]) begin
            ovf_next = 16'hFFFF;
        end else begin
            ovf_next = ovf_sum[15:0];
        end
    end

    always_comb begin
        push = grant_valid;
        pop  = out_valid && out_ready;
        level_next = fifo_level;
        if (push && !pop) begin
            level_next = fifo_level + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = fifo_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending        <= '0;
            last_grant     <= ID_WIDTH'(NUM_SENSORS - 1);
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            overflow_count <= '0;
        end else begin
            pending        <= pending_next;
            fifo_level     <= level_next;
            overflow_count <= ovf_next;
            if (grant_valid) begin
                last_grant <= grant_id;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Data storage needs no reset; validity is carried by pending and fifo_level.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_SENSORS); i++) begin
            if (data_ready[i]) begin
                hold[i] <= word_in[i];
            end
        end
        if (push) begin
            mem[wr_ptr] <= {grant_id, grant_word};
        end
    end

    always_comb begin
        head      = mem[rd_ptr];
        out_valid = (fifo_level != '0);
        out_data  = out_valid ? head[31:0] : '0;
        out_id    = out_valid ? head[32 +: ID_WIDTH] : '0;
    end

endmodule

// File: tb/tb_lighthouse_sample_arbiter.sv
// Bench for lighthouse_sample_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based transaction model.
`timescale 1ns/1ps
module tb_lighthouse_sample_arbiter;

    localparam int NS    = 8;
    localparam int IDW   = 4;
    localparam int DEPTH = 16;
    localparam int LVLW  = 5;

    logic              clk;
    logic              reset;
    logic [32*NS-1:0]  sensor_data;
    logic [NS-1:0]     data_ready;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [IDW-1:0]    out_id;
    logic [LVLW-1:0]   fifo_level;
    logic [15:0]       overflow_count;
    logic              clear_overflow;

    lighthouse_sample_arbiter #(.NUM_SENSORS(NS), .ID_WIDTH(IDW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sensor_data(sensor_data), .data_ready(data_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .fifo_level(fifo_level), .overflow_count(overflow_count), .clear_overflow(clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int id; logic [31:0] data; } entry_t;
    entry_t      m_q[$];
    bit          m_pend[NS];
    logic [31:0] m_hold[NS];
    int          m_lg;
    int          m_cnt;
    int          checks;
    int          errors;

    // Transaction-level model of one clock edge, from the block's rules.
    task automatic model_step();
        int gnt;
        int ev;
        entry_t e;
        if (reset) begin
            m_q.delete();
            for (int i = 0; i < NS; i++) m_pend[i] = 1'b0;
            m_lg  = NS - 1;
            m_cnt = 0;
            return;
        end
        gnt = -1;
        if (m_q.size() < DEPTH) begin
            for (int k = 1; k <= NS; k++) begin
                int idx;
                idx = (m_lg + k) % NS;
                if (gnt < 0 && m_pend[idx]) gnt = idx;
            end
        end
        ev = 0;
        for (int i = 0; i < NS; i++) if (data_ready[i] && m_pend[i] && i != gnt) ev++;
        if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
        if (gnt >= 0) begin
            e.id = gnt; e.data = m_hold[gnt];
            m_q.push_back(e);
            m_pend[gnt] = 1'b0;
            m_lg = gnt;
        end
        for (int i = 0; i < NS; i++) begin
            if (data_ready[i]) begin
                m_hold[i] = sensor_data[32*i +: 32];
                m_pend[i] = 1'b1;
            end
        end
        if (clear_overflow) m_cnt = (ev > 65535) ? 65535 : ev;
        else m_cnt = (m_cnt + ev > 65535) ? 65535 : m_cnt + ev;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        data_ready     = '0;
        clear_overflow = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic strobe(input int i, input logic [31:0] w);
        data_ready[i] = 1'b1;
        sensor_data[32*i +: 32] = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
        checks++; if (out_id !== 4'h0) begin errors++; $display("FAIL reset_id got %0d want 0", out_id); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (overflow_count !== 16'h0) begin errors++; $display("FAIL reset_ovf got %0d want 0", overflow_count); end
    endtask

    task automatic test_single_sensor();
        do_reset();
        out_ready = 1'b0;
        strobe(3, 32'h0000_2095);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got valid %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
        checks++; if (out_id !== 4'd3) begin errors++; $display("FAIL single_id got %0d want 3", out_id); end
        checks++; if (out_data !== 32'h0000_2095) begin errors++; $display("FAIL single_data got %h want 00002095", out_data); end
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL single_level got %0d want 1", fifo_level); end
        out_ready = 1'b1;
        tick();
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL single_drain got level %0d want 0", fifo_level); end
    endtask

    task automatic test_round_robin();
        int got_id[$];
        logic [31:0] got_data[$];
        for (int pass = 0; pass < 2; pass++) begin
            int first;
            got_id.delete(); got_data.delete();
            if (pass == 0) begin
                do_reset();
                first = 0;
            end else begin
                strobe(5, 32'h55);
                tick();
                for (int c = 0; c < 4; c++) tick();
                first = 6;
            end
            out_ready = 1'b1;
            for (int i = 0; i < NS; i++) strobe(i, 32'h100 * (pass + 1) + 32'(i));
            tick();
            for (int c = 0; c < 14; c++) begin
                tick();
                if (out_valid) begin got_id.push_back(int'(out_id)); got_data.push_back(out_data); end
            end
            checks++; if (got_id.size() != NS) begin errors++; $display("FAIL rr_count pass %0d got %0d want %0d", pass, got_id.size(), NS); end
            for (int k = 0; k < NS; k++) begin
                int eid;
                eid = (first + k) % NS;
                checks++;
                if (k >= got_id.size() || got_id[k] != eid || got_data[k] !== 32'h100 * (pass + 1) + 32'(eid)) begin
                    errors++;
                    $display("FAIL rr_order pass %0d slot %0d got id %0d data %h want id %0d", pass, k,
                             (k < got_id.size()) ? got_id[k] : -1, (k < got_data.size()) ? got_data[k] : 32'hX, eid);
                end
            end
        end
    endtask

    task automatic fill_fifo();
        out_ready = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            strobe(c % NS, 32'(c));
            tick();
        end
        tick();
    endtask

    task automatic test_overwrite();
        int n;
        int last_id;
        logic [31:0] last_data;
        do_reset();
        fill_fifo();
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovw_full got level %0d want 16", fifo_level); end
        strobe(2, 32'hA); tick();
        strobe(2, 32'hB); tick();
        checks++; if (overflow_count !== 16'd1) begin errors++; $display("FAIL ovw_count got %0d want 1", overflow_count); end
        n = 1; last_id = int'(out_id); last_data = out_data;
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (out_valid) begin n++; last_id = int'(out_id); last_data = out_data; end
        end
        checks++; if (n != 17) begin errors++; $display("FAIL ovw_drained got %0d want 17", n); end
        checks++; if (last_id != 2 || last_data !== 32'hB) begin errors++; $display("FAIL ovw_last got id %0d data %h want id 2 data b", last_id, last_data); end
        checks++; if (overflow_count !== 16'd1) begin errors++; $display("FAIL ovw_count_after got %0d want 1", overflow_count); end
    endtask

    task automatic test_collision();
        logic [31:0] got[$];
        do_reset();
        out_ready = 1'b1;
        strobe(1, 32'h11); tick();
        strobe(1, 32'h22); tick();
        if (out_valid && out_id == 4'd1) got.push_back(out_data);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid && out_id == 4'd1) got.push_back(out_data);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'h11 || got[1] !== 32'h22) begin
            errors++;
            $display("FAIL collision_order got %0d words first %h want 2 words 11,22", got.size(), (got.size() > 0) ? got[0] : 32'hX);
        end
        checks++; if (overflow_count !== 16'd0) begin errors++; $display("FAIL collision_ovf got %0d want 0", overflow_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        fill_fifo();
        for (int i = 0; i < NS; i++) strobe(i, $urandom);
        tick();
        checks++; if (overflow_count !== 16'd0) begin errors++; $display("FAIL sat_start got %0d want 0", overflow_count); end
        for (int c = 0; c < 8192; c++) begin
            for (int i = 0; i < NS; i++) strobe(i, $urandom);
            tick();
            if (c == 8190) begin
                checks++; if (overflow_count !== 16'hFFF8) begin errors++; $display("FAIL sat_ramp got %h want fff8", overflow_count); end
            end
        end
        strobe(0, 32'h1); strobe(1, 32'h2); tick();
        checks++; if (overflow_count !== 16'hFFFF) begin errors++; $display("FAIL sat_value got %h want ffff", overflow_count); end
        clear_overflow = 1'b1; strobe(3, 32'h3); tick();
        checks++; if (overflow_count !== 16'd1) begin errors++; $display("FAIL clear_with_event got %0d want 1", overflow_count); end
        clear_overflow = 1'b1; tick();
        checks++; if (overflow_count !== 16'd0) begin errors++; $display("FAIL clear_only got %0d want 0", overflow_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin strobe(c, 32'h300 + 32'(c)); tick(); end
        tick();
        checks++; if (fifo_level !== 5'd5) begin errors++; $display("FAIL mid_level got %0d want 5", fifo_level); end
        strobe(5, 32'h305); strobe(6, 32'h306); strobe(7, 32'h307); tick();
        reset = 1'b1; tick();
        checks++; if (out_valid !== 1'b0 || fifo_level !== 5'd0 || out_data !== 32'h0) begin
            errors++; $display("FAIL mid_reset got valid %b level %0d data %h want 0 0 0", out_valid, fifo_level, out_data);
        end
        strobe(0, 32'h77); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_early got valid %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 4'd0 || out_data !== 32'h77) begin
            errors++; $display("FAIL mid_new got valid %b id %0d data %h want 1 0 77", out_valid, out_id, out_data);
        end
        for (int c = 0; c < 3; c++) tick();
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL mid_stale got level %0d want 1", fifo_level); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic        e_valid;
            logic [31:0] e_data;
            int          e_id;
            data_ready = (c < 2000) ? (NS'($urandom) & NS'($urandom)) : NS'($urandom);
            for (int i = 0; i < NS; i++) sensor_data[32*i +: 32] = $urandom;
            out_ready      = (c < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clear_overflow = ($urandom_range(0, 63) == 0);
            reset          = ($urandom_range(0, 499) == 0);
            tick();
            e_valid = (m_q.size() > 0);
            e_data  = e_valid ? m_q[0].data : 32'h0;
            e_id    = e_valid ? m_q[0].id : 0;
            checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", c, out_valid, e_valid); end
            checks++; if (out_data !== e_data) begin errors++; $display("FAIL rand_data cyc %0d got %h want %h", c, out_data, e_data); end
            checks++; if (out_id !== IDW'(e_id)) begin errors++; $display("FAIL rand_id cyc %0d got %0d want %0d", c, out_id, e_id); end
            checks++; if (fifo_level !== LVLW'(m_q.size())) begin errors++; $display("FAIL rand_level cyc %0d got %0d want %0d", c, fifo_level, m_q.size()); end
            checks++; if (overflow_count !== 16'(m_cnt)) begin errors++; $display("FAIL rand_ovf cyc %0d got %0d want %0d", c, overflow_count, m_cnt); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; data_ready = '0; sensor_data = '0; out_ready = 1'b0; clear_overflow = 1'b0;
        m_lg = NS - 1; m_cnt = 0;
        for (int i = 0; i < NS; i++) begin m_pend[i] = 1'b0; m_hold[i] = '0; end
        test_reset();
        test_single_sensor();
        test_round_robin();
        test_overwrite();
        test_collision();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
